mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs: WB control, memory read/write control, ALU result, RS2 store data and destination register.
- Drives a single-port data memory through a req/ack handshake. Stalls the pipeline while an access is outstanding.
- Registers the results that the WB stage consumes, so it also acts as the MEM/WB register.
- Handles byte, half and word accesses with sign or zero extension. Handles misalignment and a bus watchdog.

Parameters:
- TIMEOUT, 255: max cycles in WAIT without mem_ack_i before the access is aborted; must be at least 1.
- CNT_W, 8: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- WB_i  in  2  {RegWrite, MemtoReg} from EX/MEM
- MEMR_i  in  1  load request
- MEMW_i  in  1  store request
- funct3_i  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- ALUout_i  in  32  effective address / ALU result
- RS2_i  in  32  store data
- RDaddr_i  in  5  destination register
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  store data, replicated across lanes
- mem_rdata_i  in  32  read word, valid with ack
- mem_ack_i  in  1  one-cycle completion strobe
- WB_o  out  2  registered WB control
- ALUout_o  out  32  registered ALU result
- MEMdata_o  out  32  registered extended load data
- RDaddr_o  out  5  registered destination
- misalign_o  out  1  one-cycle pulse: misaligned access squashed
- bus_err_o  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE, watchdog=0. All registered outputs 0. mem_req_o=0, misalign_o=0, bus_err_o=0.
- op = MEMR_i | MEMW_i. If both are set, treat as a load.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- States:
  - IDLE: if op and aligned, latch mem_addr_o/we/be/wdata into request registers, set mem_req_o=1, go WAIT. stall_o=1 combinationally in this cycle. If no op, or op misaligned, stall_o=0.
  - WAIT: mem_req_o and request registers held stable. stall_o = ~mem_ack_i. On mem_ack_i: drop mem_req_o next cycle, go IDLE.
  - WAIT, no ack: watchdog increments each cycle. Reaching TIMEOUT aborts: mem_req_o drops, bus_err_o pulses, stall_o=0 that cycle, go IDLE.
- MEM/WB register updates at every edge where stall_o=0; otherwise it holds.
  - No op: WB_o=WB_i, ALUout_o=ALUout_i, RDaddr_o=RDaddr_i, MEMdata_o=0.
  - Load acked: MEMdata_o = lane selected by addr[1:0], sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Store acked: WB_o=WB_i, normally RegWrite=0 from control.
  - Misaligned or aborted access: WB_o=2'b00 (bubble), misalign_o or bus_err_o=1 for that one cycle. No memory request is issued for a misaligned access.
- Latency: non-memory op takes 1 cycle. Memory op takes 1 (IDLE issue) + N ack cycles, so 2 cycles minimum with ack on the first WAIT cycle.
- Byte enables:
  - SB: 0001 << addr[1:0]
  - SH: 0011 << addr[1:0]
  - SW: 1111
  - loads: mem_be_o=1111, mem_we_o=0
- Store data lanes:
  - SB: {4{RS2[7:0]}}
  - SH: {2{RS2[15:0]}}
  - SW: RS2
- Ack while in IDLE (spurious) is ignored.
- Reset during WAIT abandons the access immediately, with no error pulse.

Test Plan:
- ALU op, WB_i=10, ALUout_i=0x1234, RDaddr_i=5, no mem op -> next edge WB_o=10, ALUout_o=0x1234, RDaddr_o=5; stall_o never high.
- LB addr 0x103, mem_rdata_i=0x80AABBCC, ack 3 cycles after req -> stall_o high 3 cycles; mem_addr_o=0x100; MEMdata_o=0xFFFFFF80.
- SH addr 0x22, RS2=0xDEAD5678, ack on 1st WAIT cycle -> mem_we_o=1, mem_be_o=1100, mem_wdata_o=0x56785678; stall_o=1 for 1 cycle.
- LW addr 0x06 -> no mem_req_o; misalign_o pulses once; WB_o=00; stall_o=0.
- LHU addr 0x40 with TIMEOUT=4 and no ack -> mem_req_o high for 4 cycles then drops; bus_err_o pulses; WB_o=00; pipeline resumes.
- rst_n_i low mid-WAIT -> all outputs 0 immediately (async); state IDLE after release; late ack ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a single-port data memory over req/ack, stalls while an access is
// outstanding and doubles as the MEM/WB register (sized/extended loads, misalign and watchdog).
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  WB_i,
  input  logic        MEMR_i,
  input  logic        MEMW_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] RS2_i,
  input  logic [4:0]  RDaddr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [1:0]  WB_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] MEMdata_o,
  output logic [4:0]  RDaddr_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  localparam logic [CNT_W-1:0] ToLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;

  logic [1:0]  wb_q, wb_d;
  logic [31:0] alu_q, alu_d, mdata_q, mdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        mis_q, mis_d, berr_q, berr_d;

  logic        op, misalign, issue, ack_done, abort;
  logic [31:0] lane, ext;

  assign op = MEMR_i | MEMW_i;

  always_comb begin
    unique case (funct3_i[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = ALUout_i[0];
      default: misalign = |ALUout_i[1:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (op && !misalign) state_d = StWait;
      end
      StWait: begin
        if (mem_ack_i || cnt_q == ToLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ack takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    stall_o  = 1'b0;
    issue    = 1'b0;
    ack_done = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op && !misalign) begin
          issue   = 1'b1;
          stall_o = 1'b1;
        end
      end
      StWait: begin
        if (mem_ack_i)           ack_done = 1'b1;
        else if (cnt_q == ToLast) abort   = 1'b1;
        else                      stall_o = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n_i) stall_o = 1'b0;
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    if (issue) begin
      req_d  = 1'b1;
      we_d   = MEMW_i & ~MEMR_i;
      addr_d = {ALUout_i[31:2], 2'b00};
      off_d  = ALUout_i[1:0];
      f3_d   = funct3_i;
      unique case (funct3_i[1:0])
        2'b00: begin
          be_d    = 4'b0001 << ALUout_i[1:0];
          wdata_d = {4{RS2_i[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << ALUout_i[1:0];
          wdata_d = {2{RS2_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = RS2_i;
        end
      endcase
      if (!we_d) be_d = 4'b1111;
    end else if (ack_done || abort) begin
      req_d = 1'b0;
    end
  end

  always_comb begin
    lane = mem_rdata_i >> {off_q, 3'b000};
    unique case (f3_q[1:0])
      2'b00:   ext = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   ext = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
      default: ext = mem_rdata_i;
    endcase
  end

  // MEM/WB register: advances whenever the pipeline is not stalled.
  always_comb begin
    wb_d    = wb_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    mdata_d = mdata_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    if (!stall_o) begin
      wb_d    = WB_i;
      alu_d   = ALUout_i;
      rd_d    = RDaddr_i;
      mdata_d = '0;
      if (state_q == StIdle && op && misalign) begin
        wb_d  = 2'b00;
        mis_d = 1'b1;
      end else if (abort) begin
        wb_d   = 2'b00;
        berr_d = 1'b1;
      end else if (ack_done && !we_q) begin
        mdata_d = ext;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wb_q    <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      mdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wb_q    <= wb_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      mdata_q <= mdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign WB_o        = wb_q;
  assign ALUout_o    = alu_q;
  assign MEMdata_o   = mdata_q;
  assign RDaddr_o    = rd_q;
  assign misalign_o  = mis_q;
  assign bus_err_o   = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of operations against a delayed-ack memory model, with
// expected MEM/WB results queued at issue and compared when the stage retires the operation.
module tb_mem_access_stage;

  localparam int unsigned Timeout = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [1:0]  WB_i = '0;
  logic        MEMR_i = 1'b0, MEMW_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] ALUout_i = '0, RS2_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [1:0]  WB_o;
  logic [31:0] ALUout_o, MEMdata_o;
  logic [4:0]  RDaddr_o;
  logic        misalign_o, bus_err_o;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.TIMEOUT(Timeout), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .WB_i(WB_i), .MEMR_i(MEMR_i), .MEMW_i(MEMW_i),
    .funct3_i(funct3_i), .ALUout_i(ALUout_i), .RS2_i(RS2_i), .RDaddr_i(RDaddr_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .WB_o(WB_o), .ALUout_o(ALUout_o), .MEMdata_o(MEMdata_o),
    .RDaddr_o(RDaddr_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic        memr, memw;
    logic [2:0]  f3;
    logic [31:0] addr, rs2;
    logic [4:0]  rd;
    logic [7:0]  delay;   // ack on this WAIT cycle; 0 = never ack
    logic [31:0] rdata;
    logic [7:0]  cyc;     // expected stall cycles == request cycles
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [1:0]  e_wb;
    logic [31:0] e_mdata;
    logic        e_mis, e_berr;
  } vec_t;

  int checks = 0, errors = 0;
  int ack_delay = 0, wait_cnt = 0, late_req = 0, late_seen = 0;
  logic [31:0] rd_val = '0;
  logic [1:0]  prev_wb = 2'b00;
  vec_t exp_q[$];
  vec_t tbl[16];

  // Memory model: acks on the ack_delay-th cycle of a request; late_req forces a stray ack.
  initial begin : mem_model
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (late_req != late_seen) begin
        late_seen = late_req;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
      end else if (rst_n_i && mem_req_o && ack_delay != 0) begin
        wait_cnt++;
        if (wait_cnt == ack_delay) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = rd_val;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] wb, input logic memr, input logic memw,
                              input logic [2:0] f3, input logic [31:0] addr, rs2,
                              input logic [4:0] rd, input logic [7:0] delay,
                              input logic [31:0] rdata, input logic [7:0] cyc,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic e_we, input logic [31:0] e_wdata,
                              input logic [1:0] e_wb, input logic [31:0] e_mdata,
                              input logic e_mis, e_berr);
    vec_t v;
    v = '{wb, memr, memw, f3, addr, rs2, rd, delay, rdata, cyc, e_addr, e_be, e_we, e_wdata,
          e_wb, e_mdata, e_mis, e_berr};
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge that retires the operation.
  task automatic run_op(input vec_t v);
    int stalls, reqs, bad_req, hold_bad;
    bit done;
    vec_t e;
    WB_i = v.wb; MEMR_i = v.memr; MEMW_i = v.memw; funct3_i = v.f3;
    ALUout_i = v.addr; RS2_i = v.rs2; RDaddr_i = v.rd;
    ack_delay = int'(v.delay); rd_val = v.rdata;
    exp_q.push_back(v);
    stalls = 0; reqs = 0; bad_req = 0; hold_bad = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk_i); #2;
      if (mem_req_o) begin
        reqs++;
        if (mem_addr_o !== v.e_addr || mem_be_o !== v.e_be || mem_we_o !== v.e_we ||
            (v.e_we && mem_wdata_o !== v.e_wdata)) bad_req++;
      end
      if (stall_o) begin
        stalls++;
        if (WB_o !== prev_wb) hold_bad++;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL retire_timeout: stall_o still 1 after 64 cycles, required 0");
    end
    @(posedge clk_i); #1;
    e = exp_q.pop_front();
    chk("stall_cycles", stalls, 32'(e.cyc));
    chk("req_cycles", reqs, 32'(e.cyc));
    chk("req_fields_bad", bad_req, 0);
    chk("wb_hold_bad", hold_bad, 0);
    chk("WB_o", 32'(WB_o), 32'(e.e_wb));
    chk("misalign_o", 32'(misalign_o), 32'(e.e_mis));
    chk("bus_err_o", 32'(bus_err_o), 32'(e.e_berr));
    chk("mem_req_after", 32'(mem_req_o), 0);
    if (!e.e_mis && !e.e_berr) begin
      chk("ALUout_o", ALUout_o, e.addr);
      chk("RDaddr_o", 32'(RDaddr_o), 32'(e.rd));
      if (!e.e_we) chk("MEMdata_o", MEMdata_o, e.e_mdata);
    end
    prev_wb = e.e_wb;
  endtask

  initial begin
    tbl[0]  = mk(2'b10, 0, 0, 3'b000, 32'h1234, 0, 5, 0, 0, 0, 0, 0, 0, 0,
                 2'b10, 0, 0, 0);
    tbl[1]  = mk(2'b11, 1, 0, 3'b000, 32'h103, 0, 7, 3, 32'h80AABBCC, 3, 32'h100, 4'hF, 0, 0,
                 2'b11, 32'hFFFFFF80, 0, 0);
    tbl[2]  = mk(2'b00, 0, 1, 3'b001, 32'h22, 32'hDEAD5678, 0, 1, 0, 1, 32'h20, 4'b1100, 1,
                 32'h56785678, 2'b00, 0, 0, 0);
    tbl[3]  = mk(2'b11, 1, 0, 3'b010, 32'h06, 0, 9, 0, 0, 0, 0, 0, 0, 0,
                 2'b00, 0, 1, 0);
    tbl[4]  = mk(2'b11, 1, 0, 3'b101, 32'h40, 0, 10, 0, 0, 4, 32'h40, 4'hF, 0, 0,
                 2'b00, 0, 0, 1);
    tbl[5]  = mk(2'b11, 1, 0, 3'b100, 32'h101, 0, 11, 2, 32'h1234F0AB, 2, 32'h100, 4'hF, 0, 0,
                 2'b11, 32'h000000F0, 0, 0);
    tbl[6]  = mk(2'b11, 1, 0, 3'b001, 32'h42, 0, 12, 1, 32'h80017FFF, 1, 32'h40, 4'hF, 0, 0,
                 2'b11, 32'hFFFF8001, 0, 0);
    tbl[7]  = mk(2'b11, 1, 0, 3'b101, 32'h42, 0, 13, 1, 32'h80017FFF, 1, 32'h40, 4'hF, 0, 0,
                 2'b11, 32'h00008001, 0, 0);
    tbl[8]  = mk(2'b11, 1, 0, 3'b010, 32'h200, 0, 14, 2, 32'hCAFEBABE, 2, 32'h200, 4'hF, 0, 0,
                 2'b11, 32'hCAFEBABE, 0, 0);
    tbl[9]  = mk(2'b00, 0, 1, 3'b000, 32'h13, 32'h112233A5, 0, 1, 0, 1, 32'h10, 4'b1000, 1,
                 32'hA5A5A5A5, 2'b00, 0, 0, 0);
    // Ack on the last cycle the watchdog allows must still complete normally.
    tbl[10] = mk(2'b00, 0, 1, 3'b010, 32'h30, 32'h89ABCDEF, 0, 4, 0, 4, 32'h30, 4'hF, 1,
                 32'h89ABCDEF, 2'b00, 0, 0, 0);
    tbl[11] = mk(2'b00, 0, 1, 3'b001, 32'h21, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0,
                 2'b00, 0, 1, 0);
    tbl[12] = mk(2'b11, 1, 1, 3'b010, 32'h44, 32'h5, 15, 1, 32'h0BADF00D, 1, 32'h44, 4'hF, 0, 0,
                 2'b11, 32'h0BADF00D, 0, 0);
    tbl[13] = mk(2'b11, 1, 0, 3'b000, 32'h100, 0, 16, 1, 32'h0000007F, 1, 32'h100, 4'hF, 0, 0,
                 2'b11, 32'h0000007F, 0, 0);
    tbl[14] = mk(2'b11, 1, 0, 3'b001, 32'h40, 0, 17, 1, 32'h1234ABCD, 1, 32'h40, 4'hF, 0, 0,
                 2'b11, 32'hFFFFABCD, 0, 0);
    tbl[15] = mk(2'b01, 0, 0, 3'b000, 32'hFFFF0000, 0, 31, 0, 0, 0, 0, 0, 0, 0,
                 2'b01, 0, 0, 0);

    // Reset state, with a load presented so a stall would show if not held off.
    MEMR_i = 1'b1; funct3_i = 3'b010; ALUout_i = 32'h10;
    #12;
    chk("rst_stall_o", 32'(stall_o), 0);
    chk("rst_mem_req_o", 32'(mem_req_o), 0);
    chk("rst_WB_o", 32'(WB_o), 0);
    chk("rst_ALUout_o", ALUout_o, 0);
    chk("rst_MEMdata_o", MEMdata_o, 0);
    chk("rst_RDaddr_o", 32'(RDaddr_o), 0);
    chk("rst_flags", {misalign_o, bus_err_o}, 0);
    MEMR_i = 1'b0;
    #11 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 16; i++) run_op(tbl[i]);

    // Reset in the middle of WAIT: everything clears at once, no error pulse.
    WB_i = 2'b11; MEMR_i = 1'b1; MEMW_i = 1'b0; funct3_i = 3'b010;
    ALUout_i = 32'h80; RDaddr_i = 5'd4; ack_delay = 0;
    repeat (2) @(negedge clk_i);
    #2;
    chk("wait_req_high", 32'(mem_req_o), 1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req_o), 0);
    chk("midrst_stall", 32'(stall_o), 0);
    chk("midrst_addr", mem_addr_o, 0);
    chk("midrst_be_we", {mem_be_o, mem_we_o}, 0);
    chk("midrst_mwb", {WB_o, RDaddr_o, misalign_o, bus_err_o}, 0);
    chk("midrst_data", ALUout_o | MEMdata_o, 0);
    MEMR_i = 1'b0; WB_i = 2'b00;
    @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("after_rst_berr", 32'(bus_err_o), 0);
    prev_wb = 2'b00;
    late_req++;
    run_op(mk(2'b01, 0, 0, 3'b000, 32'h55, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0));
    run_op(tbl[8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
